// File: rtl/nonce_fifo_hub.sv
// Collects golden nonces from SLAVES miners into per-slave holding registers,
// arbitrates them into a FIFO and hands them one by one to serial_transmit.
module nonce_fifo_hub #(
    parameter int SLAVES       = 4,
    parameter int NONCE_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int ARB_RR       = 1,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                            uart_clk,
    input  logic                            reset_n,
    input  logic [SLAVES-1:0]               new_nonces,
    input  logic [SLAVES*NONCE_WIDTH-1:0]   slave_nonces,
    input  logic                            serial_busy,
    input  logic                            clear_stats,
    output logic                            serial_send,
    output logic [NONCE_WIDTH-1:0]          golden_nonce,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     drop_count,
    output logic [SLAVES-1:0]               drop_flags
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [NONCE_WIDTH-1:0] pend_q [SLAVES];
    logic [NONCE_WIDTH-1:0] pend_d [SLAVES];
    logic [SLAVES-1:0]      pend_valid_q, pend_valid_d;
    logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NONCE_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [15:0]            drop_count_q, drop_count_d;
    logic [SLAVES-1:0]      drop_flags_q, drop_flags_d;
    logic [SLAVES-1:0]      drop_vec;
    logic                   gnt_vld;
    logic [SW-1:0]          gnt_idx;
    logic                   fifo_full, fifo_empty, pop;

    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic                   serial_send_q;
    logic [NONCE_WIDTH-1:0] golden_nonce_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign pop        = (state_q == IDLE) && !fifo_empty && !serial_busy;

    // Search starts at rr_ptr in round-robin mode, at slave 0 otherwise.
    always_comb begin : arb
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < SLAVES; k++) begin
            idx = ((ARB_RR != 0) ? int'(rr_ptr_q) : 0) + k;
            if (idx >= SLAVES) idx = idx - SLAVES;
            if (!gnt_vld && !fifo_full && pend_valid_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

    always_comb begin : capture
        logic        granted;
        int          ndrop;
        int          nxt;
        logic [16:0] sum;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        drop_vec     = '0;
        granted      = 1'b0;
        ndrop        = 0;
        nxt          = 0;
        for (int i = 0; i < SLAVES; i++) begin
            granted = gnt_vld && (gnt_idx == SW'(i));
            if (granted) pend_valid_d[i] = 1'b0;
            if (new_nonces[i]) begin
                pend_d[i]       = slave_nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
                pend_valid_d[i] = 1'b1;
                if (pend_valid_q[i] && !granted) drop_vec[i] = 1'b1;
            end
            ndrop = ndrop + int'(drop_vec[i]);
        end
        sum          = {1'b0, drop_count_q} + 17'(ndrop);
        drop_count_d = sum[16] ? 16'hFFFF : sum[15:0];
        drop_flags_d = drop_flags_q | drop_vec;
        if (clear_stats) begin
            drop_count_d = '0;
            drop_flags_d = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            nxt = int'(gnt_idx) + 1;
            if (nxt >= SLAVES) nxt = 0;
            rr_ptr_d = SW'(nxt);
        end
        wr_ptr_d = wr_ptr_q + PW'(gnt_vld);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLAVES; i++) pend_q[i] <= '0;
            pend_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_count_q <= '0;
            drop_flags_q <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_count_q <= drop_count_d;
            drop_flags_q <= drop_flags_d;
        end
    end

    // Storage only; occupancy is defined entirely by the reset pointers.
    always_ff @(posedge uart_clk) begin
        if (gnt_vld) fifo_mem_q[wr_ptr_q[PW-2:0]] <= pend_q[gnt_idx];
    end

    // The busy-rise timer counts down from BUSY_TIMEOUT-1, so WAIT_HI lasts
    // at most BUSY_TIMEOUT cycles before the word is abandoned.
    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            serial_send_q  <= 1'b0;
            golden_nonce_q <= '0;
        end else begin
            serial_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        golden_nonce_q <= fifo_mem_q[rd_ptr_q[PW-2:0]];
                        serial_send_q  <= 1'b1;
                        state_q        <= SEND;
                    end
                end
                SEND: begin
                    timer_q <= TW'(BUSY_TIMEOUT - 1);
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (serial_busy)          state_q <= WAIT_LO;
                    else if (timer_q == '0)   state_q <= IDLE;
                    else                      timer_q <= timer_q - 1'b1;
                end
                WAIT_LO: begin
                    if (!serial_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_send  = serial_send_q;
    assign golden_nonce = golden_nonce_q;
    assign fifo_count   = wr_ptr_q - rd_ptr_q;
    assign drop_count   = drop_count_q;
    assign drop_flags   = drop_flags_q;
endmodule

// File: doc/nonce_fifo_hub.md
Name: nonce_fifo_hub

Overview:
- Parametrised successor to the existing single-register nonce hub, in the uart_clk domain between the per-miner gn_match synchronisers and serial_transmit.
- Collects golden nonces from SLAVES miners through per-slave holding registers, a selectable fixed-priority or round-robin arbiter and a FIFO.
- Drives serial_transmit with a send/busy handshake and a busy timeout.
- Counts dropped nonces instead of losing them silently.

Parameters:
- SLAVES, 4, number of miner channels (1..16).
- NONCE_WIDTH, 32, width of each nonce word.
- FIFO_DEPTH, 8, FIFO entries; must be a power of two, 2..64.
- ARB_RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- BUSY_TIMEOUT, 15, cycles to wait for serial_busy to rise after serial_send (1..255).

Ports:
- uart_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- new_nonces  in  SLAVES  one-cycle pulses, already synchronised to uart_clk.
- slave_nonces  in  SLAVES*NONCE_WIDTH  slave i occupies bits [i*NONCE_WIDTH +: NONCE_WIDTH]; valid in the pulse cycle.
- serial_busy  in  1  transmitter busy.
- clear_stats  in  1  synchronous clear of drop_count and drop_flags.
- serial_send  out  1  one-cycle transmit request.
- golden_nonce  out  NONCE_WIDTH  word being transmitted; stable from serial_send until the next pop.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  saturating count of lost nonces.
- drop_flags  out  SLAVES  sticky per-slave loss indicator.

Behaviour:
- Async reset (reset_n=0), all cleared at once:
  - outputs: serial_send=0, golden_nonce=0, fifo_count=0, drop_count=0, drop_flags=0;
  - internal: pend_valid=0, FIFO pointers=0, round-robin pointer=0, FSM=IDLE.
- Capture stage:
  - new_nonces[i]=1 latches the slice of slave i into pend[i] and sets pend_valid[i].
  - If pend_valid[i] is already 1 and slave i is not granted in that cycle: overwrite pend[i] with the newer nonce, increment drop_count, set drop_flags[i].
  - If slave i is granted in the same cycle: the old value goes to the FIFO, the new one is latched, and nothing is dropped.
- Arbiter:
  - At most one grant per cycle, only when the FIFO is not full and some pend_valid is set.
  - The grant writes pend[g] to the FIFO and clears pend_valid[g] (unless relatched the same cycle).
  - ARB_RR=1: search starts at index rr_ptr; after a grant, rr_ptr = g+1 mod SLAVES.
  - ARB_RR=0: lowest index wins.
  - FIFO full: no grant; pending values are held; further pulses overwrite and count as drops.
- FIFO:
  - Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full = pointer MSBs differ and lower bits are equal.
  - A write and a pop in the same cycle leave fifo_count unchanged; a write while full cannot occur.
- Transmit FSM:
  - IDLE: if the FIFO is non-empty and serial_busy=0, pop the head into golden_nonce, go to SEND.
  - SEND: serial_send=1 for exactly this cycle, go to WAIT_HI, clear the timer.
  - WAIT_HI: on serial_busy=1 go to WAIT_LO. If the timer reaches BUSY_TIMEOUT, go to IDLE (word abandoned, no retry, no drop count).
  - WAIT_LO: on serial_busy=0 go to IDLE.
- Latency, with the FIFO empty, FSM IDLE and transmitter idle: pulse in cycle 0 → FIFO write at the edge ending cycle 1 → pop into golden_nonce at the edge ending cycle 2 → serial_send high in cycle 3.
- drop_count:
  - Saturates at 16'hFFFF.
  - Multiple drops in one cycle add their popcount, saturating.
- clear_stats:
  - Zeroes drop_count and drop_flags at the next edge.
  - A drop in the same cycle is lost; the clear wins.
- Reset asserted mid-transmission aborts immediately; serial_send drops asynchronously.

Test Plan:
- Single nonce: slave 2 pulses 32'hDEADBEEF with the FIFO empty → serial_send high exactly in cycle 3, golden_nonce=32'hDEADBEEF; drop_count stays 0.
- Simultaneous burst, ARB_RR=1: all 4 slaves pulse in one cycle with values 32'h0000_0000..32'h0000_0003 → transmit order 0,1,2,3. Repeating the burst → order 0,1,2,3 (rr_ptr back to 0). With ARB_RR=0 → order 0,1,2,3, and slave 0 starves others under continuous pulses.
- FIFO full: serial_busy held high, 12 distinct pulses from slave 1 spaced 3 cycles apart:
  - fifo_count saturates at 8; the 9th value is held pending;
  - pulses 10–12 overwrite it, giving drop_count=3 and drop_flags=4'b0010;
  - after serial_busy releases, the 9 survivors are transmitted in order: first 8, then pulse 12.
- Busy timeout: serial_busy tied 0 → each nonce gives one serial_send, then an IDLE return after 15 cycles; the next nonce goes out on schedule.
- Same-cycle grant plus repulse: slave 0 pending, then pulses again in its grant cycle → both values are transmitted, drop_count=0.
- Reset and stats:
  - reset_n low during WAIT_LO with 3 entries queued → fifo_count=0, serial_send=0 immediately, and no transmission after release.
  - clear_stats pulse with drop_count=5 → drop_count=0 on the next cycle.
